// File: rtl/schnorr_core_if.sv
// schnorr_core_if: bundle of the control, operand, challenge and result
// signals of schnorr_core.
//   master : drives start/mode/operands and answers the challenge request
//   slave  : the Schnorr engine itself
// Ports (all LEN wide unless noted):
//   start, mode[1:0], x_in, k_in, s_in, P_in, R_in  -> operation request
//   chal_req (1) / chal_ack (1), chal_in             -> hash handshake
//   P_out, R_out, s_out, busy, done, ok, err        -> results / status
interface schnorr_core_if #(
  parameter int LEN = 16
);
  logic           start;
  logic [1:0]     mode;
  logic [LEN-1:0] x_in;
  logic [LEN-1:0] k_in;
  logic [LEN-1:0] s_in;
  logic [LEN-1:0] P_in;
  logic [LEN-1:0] R_in;
  logic           chal_req;
  logic           chal_ack;
  logic [LEN-1:0] chal_in;
  logic [LEN-1:0] P_out;
  logic [LEN-1:0] R_out;
  logic [LEN-1:0] s_out;
  logic           busy;
  logic           done;
  logic           ok;
  logic           err;

  modport master (
    output start, mode, x_in, k_in, s_in, P_in, R_in, chal_ack, chal_in,
    input  chal_req, P_out, R_out, s_out, busy, done, ok, err
  );

  modport slave (
    input  start, mode, x_in, k_in, s_in, P_in, R_in, chal_ack, chal_in,
    output chal_req, P_out, R_out, s_out, busy, done, ok, err
  );
endinterface

// File: rtl/schnorr_core.sv
// schnorr_core: Schnorr key generation, signing and verification over the
// order-Q subgroup of Z_P* generated by G. Modular exponentiation is an
// iterative right-to-left square-and-multiply, one exponent bit per cycle.
// The challenge e = H(R||M) mod Q comes from an external hash unit over
// chal_req/chal_ack.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : schnorr_core_if.slave (operation request, hash handshake,
//              results and status)
// Build option: define CONST_TIME_EN to run every exponentiation for exactly
// LEN bit-cycles; otherwise it stops once the remaining exponent bits are 0.
//
// state  | meaning
// IDLE   | waiting for start
// EXP    | exponentiation (first cycle loads base/exponent, then one bit/cycle)
// CHAL   | chal_req high, waiting for chal_ack
// SCALAR | sign: s = (k + e*x) mod Q
// MULCMP | verify: ok = (g^s == R*P^e mod P)
// FIN    | pulse done, drop busy
module schnorr_core #(
  parameter int LEN = 16,
  parameter int P   = 23,
  parameter int Q   = 11,
  parameter int G   = 2
) (
  input logic clk,
  input logic rst,
  schnorr_core_if.slave bus
);
  localparam logic [2*LEN-1:0] P_W = (2*LEN)'(P);
  localparam logic [2*LEN-1:0] Q_W = (2*LEN)'(Q);
  localparam logic [LEN-1:0]   Q_L = LEN'(Q);
  localparam logic [LEN-1:0]   G_L = LEN'(G);
  localparam logic [LEN-1:0]   ONE = {{(LEN-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_SIGN   = 2'd1;
  localparam logic [1:0] MODE_ILL    = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_EXP, S_CHAL, S_SCALAR, S_MULCMP, S_FIN} state_t;

  function automatic logic [LEN-1:0] mulmod(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [2*LEN-1:0] w;
    w = ({{LEN{1'b0}}, a} * {{LEN{1'b0}}, b}) % P_W;
    return w[LEN-1:0];
  endfunction

  // Operands are pre-reduced mod Q, so the 2*LEN-wide sum cannot overflow.
  function automatic logic [LEN-1:0] scalar_mod(input logic [LEN-1:0] k, input logic [LEN-1:0] e,
                                                input logic [LEN-1:0] x);
    logic [2*LEN-1:0] w;
    w = ({{LEN{1'b0}}, k} + {{LEN{1'b0}}, e} * {{LEN{1'b0}}, x}) % Q_W;
    return w[LEN-1:0];
  endfunction

  state_t         state_q;
  logic [1:0]     mode_q;
  logic [LEN-1:0] x_q, k_q, s_q, pk_q, rc_q, e_q;
  logic [LEN-1:0] base_q, acc_q, exp_q, left_q;
  logic           ld_q;     // next EXP cycle loads base/exponent
  logic           phase_q;  // verify: second exponentiation (P_in^e)
  logic [LEN-1:0] p_out_q, r_out_q, s_out_q;
  logic           chal_req_q, busy_q, done_q, ok_q, err_q;
`ifdef CONST_TIME_EN
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  logic [CW-1:0]  cnt_q;
`endif

  logic [LEN-1:0] acc_mul_d, base_sq_d, acc_d, rt_d, s_calc_d;
  logic [LEN-1:0] base_ld_d, exp_ld_d;
  logic           exp_last_d;

  // Multiply is always evaluated and then selected by the exponent bit.
  assign acc_mul_d = mulmod(acc_q, base_q);
  assign base_sq_d = mulmod(base_q, base_q);
  assign acc_d     = exp_q[0] ? acc_mul_d : acc_q;
  assign rt_d      = mulmod(rc_q, acc_q);
  assign s_calc_d  = scalar_mod(k_q % Q_L, e_q, x_q % Q_L);

`ifdef CONST_TIME_EN
  assign exp_last_d = (cnt_q == '0);
`else
  assign exp_last_d = ((exp_q >> 1) == '0);
`endif

  always_comb begin
    base_ld_d = G_L;
    exp_ld_d  = '0;
    case (mode_q)
      MODE_KEYGEN: exp_ld_d = x_q % Q_L;
      MODE_SIGN:   exp_ld_d = k_q % Q_L;
      default: begin
        if (phase_q) begin
          base_ld_d = pk_q;
          exp_ld_d  = e_q;
        end else begin
          exp_ld_d  = s_q % Q_L;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      x_q        <= '0;
      k_q        <= '0;
      s_q        <= '0;
      pk_q       <= '0;
      rc_q       <= '0;
      e_q        <= '0;
      base_q     <= '0;
      acc_q      <= '0;
      exp_q      <= '0;
      left_q     <= '0;
      ld_q       <= 1'b0;
      phase_q    <= 1'b0;
      p_out_q    <= '0;
      r_out_q    <= '0;
      s_out_q    <= '0;
      chal_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef CONST_TIME_EN
      cnt_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.mode == MODE_ILL) begin
              // Reject without touching any result register.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              mode_q  <= bus.mode;
              x_q     <= bus.x_in;
              k_q     <= bus.k_in;
              s_q     <= bus.s_in;
              pk_q    <= bus.P_in;
              rc_q    <= bus.R_in;
              ok_q    <= 1'b0;
              busy_q  <= 1'b1;
              ld_q    <= 1'b1;
              phase_q <= 1'b0;
              state_q <= S_EXP;
            end
          end
        end
        S_EXP: begin
          if (ld_q) begin
            base_q <= base_ld_d;
            exp_q  <= exp_ld_d;
            acc_q  <= ONE;
            ld_q   <= 1'b0;
`ifdef CONST_TIME_EN
            cnt_q  <= CW'(LEN-1);
`endif
          end else begin
            acc_q  <= acc_d;
            base_q <= base_sq_d;
            exp_q  <= exp_q >> 1;
`ifdef CONST_TIME_EN
            cnt_q  <= cnt_q - 1'b1;
`endif
            if (exp_last_d) begin
              case (mode_q)
                MODE_KEYGEN: begin
                  p_out_q <= acc_d;
                  state_q <= S_FIN;
                end
                MODE_SIGN: begin
                  r_out_q    <= acc_d;
                  chal_req_q <= 1'b1;
                  state_q    <= S_CHAL;
                end
                default: begin
                  if (phase_q) begin
                    state_q <= S_MULCMP;  // acc_q now holds P_in^e
                  end else begin
                    left_q     <= acc_d;
                    chal_req_q <= 1'b1;
                    state_q    <= S_CHAL;
                  end
                end
              endcase
            end
          end
        end
        S_CHAL: begin
          if (chal_req_q && bus.chal_ack) begin
            e_q        <= bus.chal_in % Q_L;
            chal_req_q <= 1'b0;
            if (mode_q == MODE_SIGN) begin
              state_q <= S_SCALAR;
            end else begin
              phase_q <= 1'b1;
              ld_q    <= 1'b1;
              state_q <= S_EXP;
            end
          end
        end
        S_SCALAR: begin
          s_out_q <= s_calc_d;
          state_q <= S_FIN;
        end
        S_MULCMP: begin
          ok_q    <= (left_q == rt_d);
          state_q <= S_FIN;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.chal_req = chal_req_q;
  assign bus.P_out    = p_out_q;
  assign bus.R_out    = r_out_q;
  assign bus.s_out    = s_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ok       = ok_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_schnorr_core.sv
// tb_schnorr_core: directed-vector bench for schnorr_core (LEN=16, P=23,
// Q=11, G=2). A table of operations with hand-computed results is applied in
// sequence (results accumulate, so untouched outputs are checked as held),
// followed by hand-written sequences for stray start pulses and reset in CHAL.
module tb_schnorr_core;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  schnorr_core_if #(.LEN(16)) bus ();

  schnorr_core #(.LEN(16), .P(23), .Q(11), .G(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] x, k, s, pk, r, chal;
    int          lat;    // keygen latency, early-terminating build
    logic [15:0] exp_p, exp_r, exp_s;
    logic        exp_ok, exp_err;
  } vec_t;

  vec_t tbl [13];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(inout int d);
    @(posedge clk);
    #1;
    if (bus.done) d++;
  endtask

  task automatic garble_inputs();
    bus.x_in = 16'hFFFF;
    bus.k_in = 16'hFFFF;
    bus.s_in = 16'hFFFF;
    bus.P_in = 16'hFFFF;
    bus.R_in = 16'hFFFF;
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] x, input logic [15:0] k,
                        input logic [15:0] s, input logic [15:0] pk, input logic [15:0] r);
    @(negedge clk);
    bus.mode  = m;
    bus.x_in  = x;
    bus.k_in  = k;
    bus.s_in  = s;
    bus.P_in  = pk;
    bus.R_in  = r;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    garble_inputs();
  endtask

  // Runs one operation; answers chal_req after it has been seen high 4 cycles.
  task automatic run_op(input vec_t v, output int lat, output int dones,
                        output logic err_seen, output logic [15:0] r_req, output logic busy_bad);
    int  req_cnt;
    bit  ack_on;
    lat = -1; dones = 0; err_seen = 1'b0; r_req = '0; busy_bad = 1'b0;
    req_cnt = 0; ack_on = 1'b0;
    launch(v.mode, v.x, v.k, v.s, v.pk, v.r);
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        #1;
      end
      if (ack_on) begin
        check("chal_req_drop", 32'(bus.chal_req), 32'd0);
        bus.chal_ack = 1'b0;
        bus.chal_in  = 16'hFFFF;
        ack_on = 1'b0;
      end else if (bus.chal_req) begin
        if (req_cnt == 0) r_req = bus.R_out;
        req_cnt++;
        if (req_cnt == 4) begin
          bus.chal_ack = 1'b1;
          bus.chal_in  = v.chal;
          ack_on = 1'b1;
        end
      end
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = cyc;
          err_seen = bus.err;
          if (bus.busy) busy_bad = 1'b1;
        end
      end else if (lat < 0 && v.mode != 2'd3 && !bus.busy) begin
        busy_bad = 1'b1;
      end
      if (lat >= 0 && cyc >= lat + 3) break;
    end
  endtask

  initial begin
    int          lat, dones, exp_lat;
    logic        err_seen, busy_bad, got;
    logic [15:0] r_req;

    //            mode   x      k      s      pk     r      chal   lat  P      R      s      ok    err
    tbl[0]  = '{2'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  5, 16'd13, 16'd0,  16'd0, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd5,  0, 16'd13, 16'd8,  16'd5, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, 16'd0, 16'd0, 16'd5, 16'd13,16'd8, 16'd5,  0, 16'd13, 16'd8,  16'd5, 1'b1, 1'b0};
    tbl[3]  = '{2'd2, 16'd0, 16'd0, 16'd6, 16'd13,16'd8, 16'd5,  0, 16'd13, 16'd8,  16'd5, 1'b0, 1'b0};
    tbl[4]  = '{2'd2, 16'd0, 16'd0, 16'd5, 16'd13,16'd8, 16'd5,  0, 16'd13, 16'd8,  16'd5, 1'b1, 1'b0};
    tbl[5]  = '{2'd3, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd0,  0, 16'd13, 16'd8,  16'd5, 1'b1, 1'b1};
    tbl[6]  = '{2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  3, 16'd1,  16'd8,  16'd5, 1'b0, 1'b0};
    tbl[7]  = '{2'd0, 16'd11,16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  3, 16'd1,  16'd8,  16'd5, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd16, 0, 16'd1,  16'd8,  16'd5, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  5, 16'd16, 16'd8,  16'd5, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 16'd4, 16'd6, 16'd0, 16'd0, 16'd0, 16'd2,  0, 16'd16, 16'd18, 16'd3, 1'b0, 1'b0};
    tbl[11] = '{2'd2, 16'd0, 16'd0, 16'd3, 16'd16,16'd18,16'd2,  0, 16'd16, 16'd18, 16'd3, 1'b1, 1'b0};
    tbl[12] = '{2'd0, 16'd12,16'd0, 16'd0, 16'd0, 16'd0, 16'd0,  3, 16'd2,  16'd18, 16'd3, 1'b0, 1'b0};

    bus.start = 1'b0; bus.mode = '0; bus.chal_ack = 1'b0; bus.chal_in = '0;
    bus.x_in = '0; bus.k_in = '0; bus.s_in = '0; bus.P_in = '0; bus.R_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_P_out", 32'(bus.P_out), 32'd0);
    check("rst_R_out", 32'(bus.R_out), 32'd0);
    check("rst_s_out", 32'(bus.s_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ok", 32'(bus.ok), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_chal_req", 32'(bus.chal_req), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i], lat, dones, err_seen, r_req, busy_bad);
      check($sformatf("v%0d_dones", i), 32'(dones), 32'd1);
      check($sformatf("v%0d_err", i), 32'(err_seen), 32'(tbl[i].exp_err));
      check($sformatf("v%0d_busy", i), 32'(busy_bad), 32'd0);
      check($sformatf("v%0d_P_out", i), 32'(bus.P_out), 32'(tbl[i].exp_p));
      check($sformatf("v%0d_R_out", i), 32'(bus.R_out), 32'(tbl[i].exp_r));
      check($sformatf("v%0d_s_out", i), 32'(bus.s_out), 32'(tbl[i].exp_s));
      check($sformatf("v%0d_ok", i), 32'(bus.ok), 32'(tbl[i].exp_ok));
      if (tbl[i].mode == 2'd1)
        check($sformatf("v%0d_R_at_req", i), 32'(r_req), 32'(tbl[i].exp_r));
      if (tbl[i].mode == 2'd0 || tbl[i].mode == 2'd3) begin
        exp_lat = (tbl[i].mode == 2'd3) ? 0 : (CT ? 18 : tbl[i].lat);
        check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      end
    end

    // Sign with stray start pulses (and a stray ack) during EXP and CHAL.
    dones = 0;
    launch(2'd1, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0);
    tick(dones);
    bus.start = 1'b1; bus.mode = 2'd0; bus.x_in = 16'd5;
    bus.chal_ack = 1'b1; bus.chal_in = 16'd9;
    tick(dones);
    bus.start = 1'b0; bus.chal_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.chal_req) begin
        got = 1'b1;
        break;
      end
      tick(dones);
    end
    check("stray_reach_chal", 32'(got), 32'd1);
    check("stray_R_at_req", 32'(bus.R_out), 32'd8);
    bus.start = 1'b1; bus.mode = 2'd0;
    tick(dones);
    bus.start = 1'b0;
    tick(dones);
    check("stray_req_held", 32'(bus.chal_req), 32'd1);
    bus.chal_ack = 1'b1; bus.chal_in = 16'd5;
    tick(dones);
    bus.chal_ack = 1'b0;
    check("stray_req_drop", 32'(bus.chal_req), 32'd0);
    for (int i = 0; i < 40; i++) tick(dones);
    check("stray_dones", 32'(dones), 32'd1);
    check("stray_s_out", 32'(bus.s_out), 32'd5);
    check("stray_R_out", 32'(bus.R_out), 32'd8);
    check("stray_P_out", 32'(bus.P_out), 32'd2);
    check("stray_busy", 32'(bus.busy), 32'd0);

    // Reset while waiting in CHAL.
    dones = 0;
    launch(2'd1, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.chal_req) begin
        got = 1'b1;
        break;
      end
      tick(dones);
    end
    check("rstc_reach_chal", 32'(got), 32'd1);
    rst = 1'b1;
    tick(dones);
    rst = 1'b0;
    check("rstc_busy", 32'(bus.busy), 32'd0);
    check("rstc_chal_req", 32'(bus.chal_req), 32'd0);
    check("rstc_P_out", 32'(bus.P_out), 32'd0);
    check("rstc_R_out", 32'(bus.R_out), 32'd0);
    check("rstc_s_out", 32'(bus.s_out), 32'd0);
    check("rstc_ok", 32'(bus.ok), 32'd0);
    check("rstc_err", 32'(bus.err), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(dones);
      if (bus.chal_req || bus.busy) got = 1'b1;
    end
    check("rstc_no_done", 32'(dones), 32'd0);
    check("rstc_stays_idle", 32'(got), 32'd0);

    // Recovery after the abort.
    run_op(tbl[0], lat, dones, err_seen, r_req, busy_bad);
    check("recov_dones", 32'(dones), 32'd1);
    check("recov_P_out", 32'(bus.P_out), 32'd13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/schnorr_core.md
Name: schnorr_core
Overview:
- Parametrised, self-contained Schnorr engine with three modes: key generation, signing and verification.
- Has an internal iterative square-and-multiply modular exponentiator; the verify path is fully implemented.
- Challenge hash is external, reached over a req/ack handshake. The block sits between the PRNG (supplies x, k) and the SHA unit (supplies c).
Parameters:
LEN, 16, operand/modulus width in bits
P, 23, group prime modulus (P < 2^LEN)
Q, 11, subgroup order, Q divides P-1
G, 2, generator of order Q mod P
Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin operation; sampled only in IDLE
mode  in  2  0 keygen, 1 sign, 2 verify, 3 illegal
x_in  in  LEN  private key (keygen, sign)
k_in  in  LEN  nonce (sign)
s_in, P_in, R_in  in  LEN each  signature scalar, public key, commitment (verify)
chal_req  out  1  challenge request
chal_ack  in  1  challenge valid
chal_in  in  LEN  hash output H(R||M)
P_out, R_out, s_out  out  LEN each  results
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
ok  out  1  verify result; held until next start
err  out  1  illegal mode; pulsed together with done
Behaviour:
- Reset: every output is 0; FSM goes to IDLE. Reset mid-operation aborts immediately with no done pulse.
- All operands are captured on the start edge. Later input changes are ignored. start while busy is ignored.
- mode 3: done=1 and err=1 on the next cycle, then IDLE. Other outputs are unchanged.
- States: IDLE, EXP, CHAL, SCALAR, MULCMP, FIN.
- Exponentiator:
  - Right-to-left binary method, one exponent bit per cycle.
  - Each cycle: acc <= (acc*base) mod P if the bit is 1; base <= (base*base) mod P.
  - Products are 2*LEN wide and reduced with a combinational modulo. acc starts at 1.
- Exponent zero gives 1.
- Exponents for g^x, g^k, g^s and P^e are reduced mod Q before use.
- keygen: EXP(G, x) -> P_out; then FIN pulses done.
- sign:
  - EXP(G, k) -> R_out.
  - CHAL: chal_req=1, R_out stable.
  - SCALAR: s_out = (k + e*x) mod Q, using a 2*LEN-wide intermediate; then done.
- verify:
  - EXP(G, s) -> left.
  - CHAL: same handshake; the hash input is R_in.
  - EXP(P_in, e) -> t.
  - MULCMP: ok = (left == (R_in*t) mod P); then done.
- Challenge handshake:
  - chal_req rises on CHAL entry and holds until chal_ack is sampled high.
  - chal_in is captured at that edge; e = chal_in mod Q. chal_req is 0 the following cycle.
  - A chal_ack received while chal_req=0 is ignored.
  - CHAL has no timeout; only rst exits it.
- done is high exactly one cycle. busy falls in the same cycle done is high. A new start may be accepted in the cycle after done.
- Output registers hold their values until overwritten by a later operation of the same kind.
Optional Feature:
CONST_TIME_EN
- Defined: each EXP runs exactly LEN cycles, and the multiply is always computed and then muxed. Keygen latency is fixed at LEN+2 cycles from the start edge to done.
- Undefined: EXP ends early once the remaining exponent bits are all zero. Latency is then (index of MSB set)+1 cycles (minimum 1) plus 2.
- Results are identical either way.
Test Plan:
- Keygen, x_in=7 -> P_out=13, done single pulse, err=0; with CONST_TIME_EN, done exactly 18 cycles after start (LEN=16).
- Sign, x_in=7, k_in=3; bench answers chal_req after 4 cycles with chal_in=5 -> R_out=8 while chal_req high, s_out=5, done pulse.
- Verify, s_in=5, P_in=13, R_in=8, chal_in=5 -> ok=1 (g^s=9, R*P^e=9); repeat with s_in=6 -> ok=0.
- Illegal mode=3 start -> done=1, err=1 next cycle; P_out/R_out/s_out unchanged.
- start pulsed during sign EXP and during CHAL -> ignored, one done only; rst asserted during CHAL -> busy=0, chal_req=0, all outputs 0, no done.
- Keygen x_in=0 and x_in=11 (≡0 mod Q) -> P_out=1; chal_in=16 (≡5 mod Q) gives the same s_out=5 as chal_in=5.
